// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// Optional watchdog feature is enabled by defining WB_ARB_TIMEOUT_EN.
package wb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of the stalled-strobe watchdog counter
    localparam int unsigned WDOG_W = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after the last owner,
// wrapping from NUM_M-1 back to 0.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned IDX_W = idx_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NUM_M-1:0] gnt_o
);

    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            idx = IDX_W'((32'(last_i) + i) % NUM_M);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone N-master to 1-slave round-robin arbiter with locked cycles.
// Define WB_ARB_TIMEOUT_EN to add the stalled-strobe watchdog (m_err_o).
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_M   = 4,
    parameter int unsigned AWIDTH  = 16,
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_M-1:0]         m_cyc_i,
    input  logic [NUM_M-1:0]         m_stb_i,
    input  logic [NUM_M-1:0]         m_we_i,
    input  logic [NUM_M*AWIDTH-1:0]  m_adr_i,
    input  logic [NUM_M*DWIDTH-1:0]  m_dat_i,
    output logic [DWIDTH-1:0]        m_dat_o,
    output logic [NUM_M-1:0]         m_ack_o,
    output logic [NUM_M-1:0]         m_err_o,
    output logic [NUM_M-1:0]         gnt_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [AWIDTH-1:0]        s_adr_o,
    output logic [DWIDTH-1:0]        s_dat_o,
    input  logic [DWIDTH-1:0]        s_dat_i,
    input  logic                     s_ack_i
);

    localparam int unsigned IDX_W = idx_width(NUM_M);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT must be within 1..255");
    end

    arb_state_e         state_q;
    logic [NUM_M-1:0]   gnt_q;
    logic [IDX_W-1:0]   last_q;
    logic [NUM_M-1:0]   pick;

    logic [IDX_W-1:0]   owner_idx;
    logic               owner_cyc;
    logic               sel_stb;
    logic               sel_we;
    logic [AWIDTH-1:0]  sel_adr;
    logic [DWIDTH-1:0]  sel_dat;
    logic               wdog_hit;

    wb_rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i  (m_cyc_i),
        .last_i (last_q),
        .gnt_o  (pick)
    );

    // Owner mux; everything collapses to zero while nobody holds the grant
    always_comb begin
        owner_idx = '0;
        owner_cyc = 1'b0;
        sel_stb   = 1'b0;
        sel_we    = 1'b0;
        sel_adr   = '0;
        sel_dat   = '0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            if (gnt_q[k]) begin
                owner_idx = IDX_W'(k);
                owner_cyc = m_cyc_i[k];
                sel_stb   = m_stb_i[k];
                sel_we    = m_we_i[k];
                sel_adr   = m_adr_i[k*AWIDTH +: AWIDTH];
                sel_dat   = m_dat_i[k*DWIDTH +: DWIDTH];
            end
        end
    end

    assign s_cyc_o = (state_q == BUSY);
    assign s_stb_o = s_cyc_o & sel_stb;
    assign s_we_o  = s_cyc_o & sel_we;
    assign s_adr_o = sel_adr;
    assign s_dat_o = sel_dat;
    assign m_dat_o = s_dat_i;
    assign m_ack_o = {NUM_M{s_ack_i}} & gnt_q;
    assign gnt_o   = gnt_q;

    // Arbitration FSM: grant from IDLE, hold while owner keeps cyc, release to IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(NUM_M - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (|m_cyc_i) begin
                        gnt_q   <= pick;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_cyc || wdog_hit) begin
                        gnt_q   <= '0;
                        last_q  <= owner_idx;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_q;
    logic [WDOG_W-1:0] wdog_d;
    logic [NUM_M-1:0]  err_q;
    logic              stall;

    // Counts stalled strobe cycles; the TIMEOUT-th one forces release
    always_comb begin
        stall    = s_stb_o & ~s_ack_i;
        wdog_hit = stall && (wdog_q == WDOG_W'(TIMEOUT - 1));
        wdog_d   = wdog_q;
        if (!s_cyc_o || s_ack_i || wdog_hit) begin
            wdog_d = '0;
        end else if (stall) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= wdog_hit ? gnt_q : '0;
        end
    end

    assign m_err_o = err_q;
`else
    assign wdog_hit = 1'b0;
    assign m_err_o  = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with an integer-level arbitration model.
// Timeout scenario is exercised when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

    localparam int NUM_M   = 4;
    localparam int AWIDTH  = 16;
    localparam int DWIDTH  = 32;
    localparam int TIMEOUT = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [NUM_M-1:0]        m_cyc_i, m_stb_i, m_we_i;
    logic [NUM_M*AWIDTH-1:0] m_adr_i;
    logic [NUM_M*DWIDTH-1:0] m_dat_i;
    logic [DWIDTH-1:0]       m_dat_o;
    logic [NUM_M-1:0]        m_ack_o, m_err_o, gnt_o;
    logic                    s_cyc_o, s_stb_o, s_we_o;
    logic [AWIDTH-1:0]       s_adr_o;
    logic [DWIDTH-1:0]       s_dat_o;
    logic [DWIDTH-1:0]       s_dat_i;
    logic                    s_ack_i;

    wb_arbiter #(
        .NUM_M   (NUM_M),
        .AWIDTH  (AWIDTH),
        .DWIDTH  (DWIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m_cyc_i (m_cyc_i),
        .m_stb_i (m_stb_i),
        .m_we_i  (m_we_i),
        .m_adr_i (m_adr_i),
        .m_dat_i (m_dat_i),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .gnt_o   (gnt_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i),
        .s_ack_i (s_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Hand-computed expectations for the current cycle, set by the stimulus
    bit               lit_en = 1'b0;
    logic [NUM_M-1:0] lit_gnt, lit_ack, lit_err;
    logic             lit_cyc;
    bit               lbus_en = 1'b0;
    logic [AWIDTH-1:0] lbus_adr;
    logic [DWIDTH-1:0] lbus_dat;
    logic              lbus_we;

    function automatic bit bitof(input logic [NUM_M-1:0] v, input int k);
        logic [NUM_M-1:0] t;
        t = v >> k;
        return t[0];
    endfunction

    // Model: owner index (-1 = none), last owner, stalled count, error owner
    int mo = -1;
    int ml = NUM_M - 1;
    int mw = 0;
    int me = -1;
    bit m_to;

    always @(posedge clk_i) begin
        if (rst_i) begin
            mo = -1;
            ml = NUM_M - 1;
            mw = 0;
            me = -1;
        end else begin
            me = -1;
            if (mo < 0) begin
                for (int n = 1; n <= NUM_M; n++)
                    if (mo < 0 && bitof(m_cyc_i, (ml + n) % NUM_M)) mo = (ml + n) % NUM_M;
                mw = 0;
            end else begin
                m_to = 1'b0;
                if (s_ack_i) mw = 0;
                else if (bitof(m_stb_i, mo)) begin
                    mw = mw + 1;
                    if (TO_EN && mw == TIMEOUT) m_to = 1'b1;
                end
                if (m_to) me = mo;
                if (!bitof(m_cyc_i, mo) || m_to) begin
                    ml = mo;
                    mo = -1;
                    mw = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    logic [NUM_M-1:0]  e_gnt, e_ack, e_err;
    logic [AWIDTH-1:0] e_adr;
    logic [DWIDTH-1:0] e_dat;

    always @(negedge clk_i) begin
        if (chk_en) begin
            e_gnt = (mo >= 0) ? (NUM_M'(1) << mo) : '0;
            e_ack = s_ack_i ? e_gnt : '0;
            e_err = (me >= 0) ? (NUM_M'(1) << me) : '0;
            chk("gnt_o",   64'(gnt_o),   64'(e_gnt));
            chk("m_ack_o", 64'(m_ack_o), 64'(e_ack));
            chk("m_err_o", 64'(m_err_o), 64'(e_err));
            chk("s_cyc_o", 64'(s_cyc_o), 64'(mo >= 0));
            chk("m_dat_o", 64'(m_dat_o), 64'(s_dat_i));
            if (mo >= 0) begin
                e_adr = AWIDTH'(m_adr_i >> (mo * AWIDTH));
                e_dat = DWIDTH'(m_dat_i >> (mo * DWIDTH));
                chk("s_stb_o", 64'(s_stb_o), 64'(bitof(m_stb_i, mo)));
                chk("s_we_o",  64'(s_we_o),  64'(bitof(m_we_i, mo)));
                chk("s_adr_o", 64'(s_adr_o), 64'(e_adr));
                chk("s_dat_o", 64'(s_dat_o), 64'(e_dat));
            end else begin
                chk("s_stb_o", 64'(s_stb_o), 64'(0));
            end
            if (lit_en) begin
                chk("lit_gnt", 64'(gnt_o),   64'(lit_gnt));
                chk("lit_ack", 64'(m_ack_o), 64'(lit_ack));
                chk("lit_err", 64'(m_err_o), 64'(lit_err));
                chk("lit_cyc", 64'(s_cyc_o), 64'(lit_cyc));
            end
            if (lbus_en) begin
                chk("lit_adr", 64'(s_adr_o), 64'(lbus_adr));
                chk("lit_dat", 64'(s_dat_o), 64'(lbus_dat));
                chk("lit_we",  64'(s_we_o),  64'(lbus_we));
            end
        end
    end

    task automatic go(input logic [3:0] cyc, input logic [3:0] stb, input logic [3:0] we,
                      input logic ack, input logic rst);
        @(posedge clk_i);
        #1;
        rst_i   = rst;
        m_cyc_i = cyc;
        m_stb_i = stb;
        m_we_i  = we;
        s_ack_i = ack;
        s_dat_i = $urandom;
        lit_en  = 1'b0;
        lbus_en = 1'b0;
    endtask

    task automatic lit(input logic [3:0] g, input logic [3:0] a, input logic [3:0] r, input logic c);
        lit_en  = 1'b1;
        lit_gnt = g;
        lit_ack = a;
        lit_err = r;
        lit_cyc = c;
    endtask

    task automatic lbus(input logic [AWIDTH-1:0] adr, input logic [DWIDTH-1:0] dat, input logic we);
        lbus_en  = 1'b1;
        lbus_adr = adr;
        lbus_dat = dat;
        lbus_we  = we;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst_i   = 1'b1;
        m_cyc_i = '0;
        m_stb_i = '0;
        m_we_i  = '0;
        m_adr_i = '0;
        m_dat_i = '0;
        s_dat_i = '0;
        s_ack_i = 1'b0;

        // Reset state, with a stray slave ack
        go(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
        chk_en = 1'b1;
        lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        lit(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Masters 1 and 2 request: 1 first, then 2 after one IDLE cycle
        go(4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        go(4'b0110, 4'b0110, 4'b0000, 1'b0, 1'b0); lit(4'b0010, 4'b0000, 4'b0000, 1'b1);
        go(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0); lit(4'b0010, 4'b0000, 4'b0000, 1'b1);
        go(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0100, 4'b0000, 4'b0000, 1'b1);
        // Ack while IDLE goes nowhere
        go(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // All four request; each owner takes one ack and drops cyc in the same cycle
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        go(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int j = 0; j < 5; j++) begin
            go(4'b1111 & ~(4'b0001 << order[j]), 4'b1111, 4'b0000, 1'b1, 1'b0);
            lit(4'b0001 << order[j], 4'b0001 << order[j], 4'b0000, 1'b1);
            go(4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
            lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0010, 4'b0000, 4'b0000, 1'b1);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Master 2 write, acked on the fourth BUSY cycle; master 0 requests meanwhile
        m_adr_i = {16'h1113, 16'h00A4, 16'h1111, 16'h1110};
        m_dat_i = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
        go(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        go(4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b0); lit(4'b0100, 4'b0000, 4'b0000, 1'b1);
        lbus(16'h00A4, 32'hDEADBEEF, 1'b1);
        for (int j = 0; j < 2; j++) begin
            go(4'b0101, 4'b0101, 4'b0100, 1'b0, 1'b0); lit(4'b0100, 4'b0000, 4'b0000, 1'b1);
            lbus(16'h00A4, 32'hDEADBEEF, 1'b1);
        end
        go(4'b0101, 4'b0101, 4'b0100, 1'b1, 1'b0); lit(4'b0100, 4'b0100, 4'b0000, 1'b1);
        lbus(16'h00A4, 32'hDEADBEEF, 1'b1);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0100, 4'b0000, 4'b0000, 1'b1);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Reset during master 1 ownership; master 0 then wins
        go(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        go(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0); lit(4'b0010, 4'b0000, 4'b0000, 1'b1);
        go(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b1); lit(4'b0010, 4'b0000, 4'b0000, 1'b1);
        go(4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0001, 4'b0000, 4'b0000, 1'b1);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);

        // Master 3 strobes with no ack
        go(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int j = 0; j < 8; j++) begin
            go(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0); lit(4'b1000, 4'b0000, 4'b0000, 1'b1);
        end
`ifdef WB_ARB_TIMEOUT_EN
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b1000, 1'b0);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
`else
        for (int j = 0; j < 4; j++) begin
            go(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0); lit(4'b1000, 4'b0000, 4'b0000, 1'b1);
        end
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b1000, 4'b0000, 4'b0000, 1'b1);
        go(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0); lit(4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif

        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
